// File: rtl/serial_adder_if.sv
// Bus bundle for serial_adder: operand request in, status and result out.
// start is taken only while busy=0; done pulses for one cycle when sum/carry/overflow update.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one full-adder cell plus carry flop.
// Define SERIAL_ADDER_SUB_EN to honour the sub input (B inversion, carry-in of 1).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_adder_if.slave    bus,
    output logic [1:0]       dbg_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;

    // Full adder built from two half-adders and a carry OR.
    logic ha1_s, ha1_c, ha2_s, ha2_c, c_next;
    assign ha1_s  = sh_a[0] ^ sh_b[0];
    assign ha1_c  = sh_a[0] & sh_b[0];
    assign ha2_s  = ha1_s ^ c;
    assign ha2_c  = ha1_s & c;
    assign c_next = ha1_c | ha2_c;

    logic             sub_eff;
    logic [WIDTH-1:0] b_load;
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_eff = bus.sub;
    assign b_load  = bus.b ^ {WIDTH{sub_eff}};
`else
    // Port kept for bench compatibility; masked to a constant 0 so no mux is built.
    assign sub_eff = bus.sub & 1'b0;
    assign b_load  = bus.b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            res     <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        sh_a  <= bus.a;
                        sh_b  <= b_load;
                        c     <= sub_eff;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    res  <= {ha2_s, res[WIDTH-1:1]};
                    c    <= c_next;
                    if (cnt == LAST_BIT) begin
                        // c is the carry into the MSB here, c_next the carry out of it.
                        sum_q   <= {ha2_s, res[WIDTH-1:1]};
                        carry_q <= c_next;
                        ovf_q   <= c ^ c_next;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == S_RUN);
    assign bus.done     = (state == S_DONE);
    assign bus.sum      = sum_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign dbg_state    = state;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: vector table, hand-built corner sequences and random ops
// checked against an arithmetic reference model.
module tb_serial_adder;
    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] prev_sum;
    logic         prev_carry;
    logic         prev_ovf;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic void model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic co, output logic o);
        int  sx, sy, sr, u;
        logic se;
`ifdef SERIAL_ADDER_SUB_EN
        se = s;
`else
        se = s & 1'b0;
`endif
        sx = int'(x);
        if (x[W-1]) sx -= (1 << W);
        sy = int'(y);
        if (y[W-1]) sy -= (1 << W);
        if (!se) begin
            u  = int'(x) + int'(y);
            co = (u >= (1 << W));
            sr = sx + sy;
        end else begin
            u  = int'(x) - int'(y);
            co = (x >= y);
            sr = sx - sy;
        end
        r = u[W-1:0];
        o = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    endfunction

    // driver: called at a negedge; returns at the negedge of the done cycle.
    task automatic do_op(input logic s_in, input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                         input int inject_at, input string tag);
        logic [W-1:0] es;
        logic         ec, eo;
        int           n, busy_cnt, both;
        model(s_in, a_in, b_in, es, ec, eo);
        exp_q.push_back(es);
        bus.start = 1'b1;
        bus.sub   = s_in;
        bus.a     = a_in;
        bus.b     = b_in;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        busy_cnt = 0;
        both = 0;
        while (!bus.done && n < 4 * W) begin
            if (bus.busy) busy_cnt++;
            if (n == 1) begin
                check({tag, "_hold_sum"}, 32'(bus.sum), 32'(prev_sum));
                check({tag, "_hold_flags"}, {30'd0, bus.carry, bus.overflow}, {30'd0, prev_carry, prev_ovf});
            end
            if (n == inject_at) begin
                bus.start = 1'b1;
                bus.sub   = ~s_in;
                bus.a     = ~a_in;
                bus.b     = a_in ^ 8'h5A;
            end else if (n == inject_at + 1) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        if (bus.busy && bus.done) both = 1;
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({tag, "_busy_in_done"}, 32'(both), 32'd0);
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp_q.pop_front()));
        check({tag, "_carry"}, 32'(bus.carry), 32'(ec));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(eo));
        prev_sum   = es;
        prev_carry = ec;
        prev_ovf   = eo;
    endtask

    int done_seen;

    initial begin
        tbl.push_back('{sub: 1'b0, a: 8'h5A, b: 8'h3C, sum: 8'h96, carry: 1'b0, ovf: 1'b1});
        tbl.push_back('{sub: 1'b0, a: 8'hFF, b: 8'h01, sum: 8'h00, carry: 1'b1, ovf: 1'b0});
        tbl.push_back('{sub: 1'b0, a: 8'h7F, b: 8'h01, sum: 8'h80, carry: 1'b0, ovf: 1'b1});
        tbl.push_back('{sub: 1'b0, a: 8'h80, b: 8'h80, sum: 8'h00, carry: 1'b1, ovf: 1'b1});
        tbl.push_back('{sub: 1'b0, a: 8'h00, b: 8'h00, sum: 8'h00, carry: 1'b0, ovf: 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        tbl.push_back('{sub: 1'b1, a: 8'h10, b: 8'h20, sum: 8'hF0, carry: 1'b0, ovf: 1'b0});
        tbl.push_back('{sub: 1'b1, a: 8'h80, b: 8'h01, sum: 8'h7F, carry: 1'b1, ovf: 1'b1});
`else
        tbl.push_back('{sub: 1'b1, a: 8'h10, b: 8'h20, sum: 8'h30, carry: 1'b0, ovf: 1'b0});
`endif

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        prev_sum   = '0;
        prev_carry = 1'b0;
        prev_ovf   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sum", 32'(bus.sum), 32'd0);
        check("reset_flags", {30'd0, bus.carry, bus.overflow}, 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // table vectors, each followed by an idle cycle
        for (int i = 0; i < tbl.size(); i++) begin
            do_op(tbl[i].sub, tbl[i].a, tbl[i].b, -1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_tbl_sum", i), 32'(bus.sum), 32'(tbl[i].sum));
            check($sformatf("vec%0d_tbl_flags", i), {30'd0, bus.carry, bus.overflow},
                  {30'd0, tbl[i].carry, tbl[i].ovf});
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {30'd0, bus.done, bus.busy}, 32'd0);
        end

        // start mid-run is ignored; start in the done cycle is taken back-to-back
        do_op(1'b0, 8'h5A, 8'h3C, 3, "ignore");
        do_op(1'b0, 8'h12, 8'h34, -1, "b2b");
        @(negedge clk);

        // reset mid-run aborts with no done pulse
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 8'h33;
        bus.b     = 8'h44;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_flags", {30'd0, bus.carry, bus.overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        prev_sum   = '0;
        prev_carry = 1'b0;
        prev_ovf   = 1'b0;
        do_op(1'b0, 8'h21, 8'h42, -1, "after_abort");
        @(negedge clk);

        // random operations, some back-to-back
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), -1, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) != 0) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
